booth_seq_ctrl: RTL and testbench



---
 rtl/booth_seq_ctrl.sv | 124 ++++++++++++
 tb/tb_booth_seq_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: iterative radix-4 Booth multiplier sequencer.
// Recodes one Booth triplet of the multiplier per clock and accumulates the
// matching partial product (0, +-X, +-2X) into a 2W-bit product.
module booth_seq_ctrl #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           signed_mode,
    input  logic           flush,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product
);
    localparam int PW = 2 * W;
    localparam int CW = $clog2(W / 2 + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    // Multiplicand, already extended to 2W and pre-shifted by 2*cnt so the
    // per-cycle shift of the partial product is a fixed 2-bit move.
    logic [PW-1:0] xs;
    // Multiplier {ext, ext, y, y[-1]}; shifted right by 2 each cycle so the
    // current triplet is always ye[2:0]. The duplicated ext bit supplies the
    // top of the extra unsigned-mode triplet.
    logic [W+2:0]  ye;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_last;
    logic [PW-1:0] pp;
    logic [PW-1:0] acc_nxt;
    logic          ext;

    assign ext = signed_mode & y[W-1];

    // Booth digit select: partial product for the current triplet
    always_comb begin
        pp = '0;
        case (ye[2:0])
            3'b001, 3'b010: pp = xs;
            3'b011:         pp = {xs[PW-2:0], 1'b0};
            3'b100:         pp = -{xs[PW-2:0], 1'b0};
            3'b101, 3'b110: pp = -xs;
            default:        pp = '0;
        endcase
        acc_nxt = acc + pp;
    end

    // Sequencer FSM with registered handshake outputs and datapath state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
            xs        <= '0;
            ye        <= '0;
            acc       <= '0;
            cnt       <= '0;
            cnt_last  <= '0;
        end else if (flush) begin
            // Abort wins over everything; an operand offered now is dropped
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xs       <= signed_mode ? {{(PW-W){x[W-1]}}, x} : {{(PW-W){1'b0}}, x};
                        ye       <= {ext, ext, y, 1'b0};
                        acc      <= '0;
                        cnt      <= '0;
                        // Unsigned needs one extra triplet to absorb y[W-1]
                        cnt_last <= signed_mode ? CW'(W/2 - 1) : CW'(W/2);
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    xs  <= {xs[PW-3:0], 2'b00};
                    ye  <= {ye[W+2], ye[W+2], ye[W+2:2]};
                    cnt <= cnt + 1'b1;
                    if (cnt == cnt_last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        product   <= acc_nxt;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed and randomized bench for booth_seq_ctrl.
module tb_booth_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        signed_mode;
    logic        flush;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    int pass_cnt = 0;
    int total    = 0;
    int fail_cnt = 0;

    booth_seq_ctrl #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .signed_mode(signed_mode), .flush(flush), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sm);
        logic [63:0] ae, be;
        ae = sm ? {{32{a[31]}}, a} : {32'b0, a};
        be = sm ? {{32{b[31]}}, b} : {32'b0, b};
        return ae * be;
    endfunction

    // Offer one operand pair on the next edge (block must be idle)
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic sm);
        x = a; y = b; signed_mode = sm; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, returning the number of edges waited
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Full directed transaction with latency and product checks
    task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sm, input logic [63:0] exp, input int exp_lat);
        int lat;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        accept(a, b, sm);
        wait_done(lat);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_product"}, product, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    initial begin
        int lat;
        logic [63:0] held;
        logic [31:0] ra, rb;
        logic rs;
        logic seen;
        int guard;

        rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; signed_mode = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        chk("reset_outputs", {60'd0, in_ready, busy, out_valid, 1'b0}, {60'd0, 4'b1000});
        chk("reset_product", product, 64'd0);
        rst_n = 1'b1;
        tick();

        txn("s_3x-5", 32'h00000003, 32'hFFFFFFFB, 1'b1, 64'hFFFFFFFFFFFFFFF1, 16);
        txn("u_ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 17);
        txn("s_ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 16);
        txn("s_minxmin", 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 16);

        // busy during RUN
        accept(32'h7FFFFFFF, 32'h80000000, 1'b1);
        chk("busy_in_run", {62'd0, busy, in_ready}, 64'b10);
        wait_done(lat);
        chk("maxxmin_product", product, 64'hC000000080000000);
        // Backpressure: hold 5 cycles, pulse an operand that must be ignored
        held = product;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin x = 32'd9; y = 32'd9; in_valid = 1'b1; end
            tick();
            in_valid = 1'b0;
            chk("bp_hold_product", product, held);
            chk("bp_hold_flags", {62'd0, out_valid, in_ready}, 64'b10);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {62'd0, in_ready, out_valid}, 64'b10);

        // Flush on the 8th RUN cycle
        accept(32'd1234, 32'd5678, 1'b1);
        repeat (7) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_flags", {61'd0, busy, in_ready, out_valid}, 64'b010);
        chk("flush_product", product, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", 64'(seen), 64'd0);
        txn("s_7x6", 32'd7, 32'd6, 1'b1, 64'd42, 16);

        // Flush in IDLE with an operand offered: not accepted
        x = 32'd3; y = 32'd3; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_drop", {62'd0, busy, in_ready}, 64'b01);

        // Asynchronous reset mid-RUN
        accept(32'd100, 32'd200, 1'b0);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {61'd0, in_ready, busy, out_valid}, 64'b100);
        chk("async_rst_product", product, 64'd0);
        #3 rst_n = 1'b1;
        tick();

        // Random pairs with random consumer backpressure
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            if (n % 8 == 0) ra = {ra[31], 31'h0};
            accept(ra, rb, rs);
            wait_done(lat);
            chk("rand_product", product, ref_mul(ra, rb, rs));
            guard = 0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
                guard++;
            end while (!out_ready && guard < 50);
            out_ready = 1'b0;
            if (guard >= 50) chk("rand_handshake_timeout", 64'(guard), 64'd0);
        end
        chk("rand_end_idle", {62'd0, in_ready, out_valid}, 64'b10);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
